// File: rtl/mips_alu_exec_unit.sv
// Registered MIPS execute-stage ALU: ALUOp/funct decode feeding a 32-bit ALU.
// The result and flags are captured one cycle after in_valid.
module mips_alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   output logic [3:0]       alu_ctrl,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out,
   output logic             illegal
);

   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLT = 4'b0111;
   localparam logic [3:0] CTRL_NOR = 4'b1100;
   localparam logic [3:0] CTRL_ILL = 4'b1111;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             ov_add;
   logic             ov_sub;
   logic [WIDTH-1:0] res_c;
   logic             ov_c;
   logic             co_c;
   logic             ill_c;

   always_comb begin
      alu_ctrl = CTRL_ILL;
      case (alu_op)
         2'b00: alu_ctrl = CTRL_ADD;
         2'b01: alu_ctrl = CTRL_SUB;
         2'b10: begin
            case (funct)
               6'b100000: alu_ctrl = CTRL_ADD;
               6'b100010: alu_ctrl = CTRL_SUB;
               6'b100100: alu_ctrl = CTRL_AND;
               6'b100101: alu_ctrl = CTRL_OR;
               6'b101010: alu_ctrl = CTRL_SLT;
               6'b100111: alu_ctrl = CTRL_NOR;
               default:   alu_ctrl = CTRL_ILL;
            endcase
         end
         default: alu_ctrl = CTRL_ILL;
      endcase
   end

   // Subtraction as a + ~b + 1, so diff[WIDTH] is the no-borrow flag.
   assign sum    = {1'b0, a} + {1'b0, b};
   assign diff   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign ov_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   assign ov_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      res_c = '0;
      ov_c  = 1'b0;
      co_c  = 1'b0;
      ill_c = 1'b0;
      case (alu_ctrl)
         CTRL_AND: res_c = a & b;
         CTRL_OR:  res_c = a | b;
         CTRL_NOR: res_c = ~(a | b);
         CTRL_ADD: begin
            res_c = sum[WIDTH-1:0];
            ov_c  = ov_add;
            co_c  = sum[WIDTH];
         end
         CTRL_SUB: begin
            res_c = diff[WIDTH-1:0];
            ov_c  = ov_sub;
            co_c  = diff[WIDTH];
         end
         CTRL_SLT: res_c = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ov_sub};
         default:  ill_c = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result    <= res_c;
            zero      <= (res_c == '0);
            overflow  <= ov_c;
            carry_out <= co_c;
            illegal   <= ill_c;
         end
      end
   end

endmodule

// File: tb/tb_mips_alu_exec_unit.sv
// Self-checking bench for mips_alu_exec_unit: directed cases plus random
// traffic compared against an arithmetic reference model.
module tb_mips_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [1:0]  alu_op = '0;
   logic [5:0]  funct = '0;
   logic [3:0]  alu_ctrl;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        carry_out;
   logic        illegal;

   int n_cmp = 0;
   int n_bad = 0;

   // expected registered state
   logic        m_vld = 1'b0;
   logic [31:0] m_res = '0;
   logic        m_ov = 1'b0;
   logic        m_co = 1'b0;
   logic        m_il = 1'b0;

   mips_alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
      .alu_op(alu_op), .funct(funct), .alu_ctrl(alu_ctrl),
      .out_valid(out_valid), .result(result), .zero(zero),
      .overflow(overflow), .carry_out(carry_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] x, input logic [31:0] y,
                                 output logic [3:0] c, output logic [31:0] r,
                                 output logic ov, output logic co, output logic il);
      longint sx, sy, s;
      longint ux, uy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'h0, x});
      uy = longint'({32'h0, y});
      c = 4'b1111;
      if (op == 2'b00) c = 4'b0010;
      else if (op == 2'b01) c = 4'b0110;
      else if (op == 2'b10) begin
         if (f == 6'd32) c = 4'b0010;
         else if (f == 6'd34) c = 4'b0110;
         else if (f == 6'd36) c = 4'b0000;
         else if (f == 6'd37) c = 4'b0001;
         else if (f == 6'd42) c = 4'b0111;
         else if (f == 6'd39) c = 4'b1100;
      end
      r = '0; ov = 1'b0; co = 1'b0; il = 1'b0;
      case (c)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b1100: r = ~(x | y);
         4'b0010: begin
            s  = sx + sy;
            r  = 32'(ux + uy);
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            co = (ux + uy) > 64'sd4294967295;
         end
         4'b0110: begin
            s  = sx - sy;
            r  = 32'(ux - uy);
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            co = (ux >= uy);
         end
         4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
         default: il = 1'b1;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
      chk({tag, ".result"},    64'(result),    64'(m_res));
      chk({tag, ".zero"},      64'(zero),      64'(m_res == 32'h0));
      chk({tag, ".overflow"},  64'(overflow),  64'(m_ov));
      chk({tag, ".carry_out"}, 64'(carry_out), 64'(m_co));
      chk({tag, ".illegal"},   64'(illegal),   64'(m_il));
   endtask

   task automatic step(input string tag, input logic v, input logic [1:0] op,
                       input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      logic [3:0]  c;
      logic [31:0] r;
      logic        ov, co, il;
      @(negedge clk);
      in_valid = v; alu_op = op; funct = f; a = x; b = y;
      #1;
      model(op, f, x, y, c, r, ov, co, il);
      chk({tag, ".alu_ctrl"}, 64'(alu_ctrl), 64'(c));
      if (v) begin
         m_res = r; m_ov = ov; m_co = co; m_il = il;
      end
      m_vld = v;
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      m_vld = 1'b0; m_res = '0; m_ov = 1'b0; m_co = 1'b0; m_il = 1'b0;
   endtask

   initial begin
      logic [5:0]  fsel [8];
      logic [31:0] corner [6];
      logic [31:0] x, y;
      logic [5:0]  f;
      fsel   = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd63};
      corner = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};

      // async reset between edges
      #7 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("reset");
      #4 rst_n = 1'b1;

      step("add5_7",   1'b1, 2'b10, 6'd32, 32'd5, 32'd7);
      chk("add5_7.value", 64'(result), 64'd12);
      step("addov",    1'b1, 2'b00, 6'd0, 32'h7FFFFFFF, 32'h1);
      chk("addov.value", 64'({overflow, carry_out, result}), 64'({2'b10, 32'h80000000}));
      step("addcarry", 1'b1, 2'b00, 6'd0, 32'hFFFFFFFF, 32'h1);
      chk("addcarry.value", 64'({zero, overflow, carry_out}), 64'(3'b101));
      step("subeq",    1'b1, 2'b01, 6'd0, 32'h12345678, 32'h12345678);
      chk("subeq.value", 64'({zero, carry_out}), 64'(2'b11));
      step("subov",    1'b1, 2'b01, 6'd0, 32'h80000000, 32'h1);
      chk("subov.value", 64'({overflow, result}), 64'({1'b1, 32'h7FFFFFFF}));
      step("slt_m1_1", 1'b1, 2'b10, 6'd42, 32'hFFFFFFFF, 32'h1);
      chk("slt_m1_1.value", 64'(result), 64'd1);
      step("slt_1_m1", 1'b1, 2'b10, 6'd42, 32'h1, 32'hFFFFFFFF);
      chk("slt_1_m1.value", 64'({zero, result}), 64'({1'b1, 32'h0}));
      step("slt_min",  1'b1, 2'b10, 6'd42, 32'h80000000, 32'h7FFFFFFF);
      chk("slt_min.value", 64'(result), 64'd1);
      step("and",      1'b1, 2'b10, 6'd36, 32'h0F0F00FF, 32'h00FF0F0F);
      chk("and.value", 64'(result), 64'h000F000F);
      step("or",       1'b1, 2'b10, 6'd37, 32'h0F0F00FF, 32'h00FF0F0F);
      chk("or.value", 64'(result), 64'h0FFF0FFF);
      step("nor",      1'b1, 2'b10, 6'd39, 32'h0F0F00FF, 32'h00FF0F0F);
      chk("nor.value", 64'(result), 64'hF000F000);
      step("illegal",  1'b1, 2'b10, 6'd0, 32'h5, 32'h9);
      chk("illegal.value", 64'({illegal, zero, result}), 64'({2'b11, 32'h0}));
      step("hold",     1'b0, 2'b00, 6'd0, 32'h1, 32'h1);
      step("op11",     1'b1, 2'b11, 6'd32, 32'h3, 32'h4);

      // reset held across an edge discards the in-flight operation
      @(negedge clk);
      in_valid = 1'b1; alu_op = 2'b00; a = 32'h10; b = 32'h20;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outputs("midreset.after");
      step("postreset", 1'b1, 2'b01, 6'd0, 32'h20, 32'h30);

      for (int i = 0; i < 400; i++) begin
         x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 7) == 0) y = x;
         f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 7)];
         step("rand", ($urandom_range(0, 4) != 0), 2'($urandom), f, x, y);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
